// File: rtl/calc_op_driver.sv
// Purpose: queues calculator commands and issues them one at a time. Define CALC_OPCHK_EN to reject opcodes 6/7 with res_err.
// Latency: LATENCY+1 cycles from push into an idle, empty FIFO to res_valid (1 cycle for a rejected opcode).
// Backpressure: cmd_ready low while the FIFO is full; a stalled result parks the FSM in HOLD and no further pops occur.
module calc_op_driver #(
   parameter int CMD_DEPTH = 4,
   parameter int LATENCY   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic        cmd_cplx,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   input  logic [15:0] cmd_ai,
   input  logic [15:0] cmd_bi,
   output logic [2:0]  chooser,
   output logic        isComplex,
   output logic [15:0] A,
   output logic [15:0] B,
   output logic [15:0] Ai,
   output logic [15:0] Bi,
   input  logic [31:0] y1,
   input  logic [31:0] y2,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_y1,
   output logic [31:0] res_y2,
   output logic [2:0]  res_op,
   output logic        res_err
);

   localparam int AW = $clog2(CMD_DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef struct packed {
      logic [2:0]  op;
      logic        cplx;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] ai;
      logic [15:0] bi;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   cmd_t          mem [CMD_DEPTH];
   cmd_t          cmd_in;
   cmd_t          head;
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [AW:0]   wr_ptr_nxt;
   logic [AW:0]   rd_ptr_nxt;
   logic          empty;
   logic          full_nxt;
   logic          push;
   logic          pop;
   logic          head_bad;
   state_t        state;
   logic [CW-1:0] cnt;

   assign cmd_in = '{op: cmd_op, cplx: cmd_cplx, a: cmd_a, b: cmd_b, ai: cmd_ai, bi: cmd_bi};
   assign head   = mem[rd_ptr[AW-1:0]];

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty      = (wr_ptr == rd_ptr);
   assign push       = cmd_valid && cmd_ready;
   assign pop        = (state == IDLE) && !empty;
   assign wr_ptr_nxt = wr_ptr + (AW+1)'(push);
   assign rd_ptr_nxt = rd_ptr + (AW+1)'(pop);
   assign full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                       (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);

`ifdef CALC_OPCHK_EN
   assign head_bad = (head.op[2:1] == 2'b11);
`else
   assign head_bad = 1'b0;
`endif

   // FIFO pointers; cmd_ready is registered from next-cycle fullness so it is low for the first cycle out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cmd_ready <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         cmd_ready <= !full_nxt;
      end
   end

   // FIFO storage; contents are don't-care whenever the pointers say empty, so no reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= cmd_in;
   end

   // Issue/wait/return sequencer: one op in flight, operands held on the calculator until y1/y2 are captured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         chooser   <= 3'b111;
         isComplex <= 1'b0;
         A         <= '0;
         B         <= '0;
         Ai        <= '0;
         Bi        <= '0;
         res_valid <= 1'b0;
         res_y1    <= '0;
         res_y2    <= '0;
         res_op    <= '0;
         res_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  if (head_bad) begin
                     // Rejected opcode never reaches the calculator; answer immediately.
                     res_valid <= 1'b1;
                     res_err   <= 1'b1;
                     res_y1    <= '0;
                     res_y2    <= '0;
                     res_op    <= head.op;
                     state     <= HOLD;
                  end else begin
                     chooser   <= head.op;
                     isComplex <= head.cplx;
                     A         <= head.a;
                     B         <= head.b;
                     Ai        <= head.ai;
                     Bi        <= head.bi;
                     cnt       <= CW'(LATENCY - 1);
                     state     <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  res_y1    <= y1;
                  res_y2    <= y2;
                  res_op    <= chooser;
                  res_err   <= 1'b0;
                  res_valid <= 1'b1;
                  chooser   <= 3'b111;
                  state     <= HOLD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
